spi_s_rx: RTL and testbench

//  SPI slave receiver: far end of the spi_m link. Oversamples cs/sclk/mosi in its own clk domain,

---
 rtl/spi_s_rx_pkg.sv | 15 +
 rtl/spi_s_rx_if.sv | 15 +
 rtl/spi_s_rx_sync.sv | 29 ++
 rtl/spi_s_rx.sv | 129 ++++++++++++
 tb/tb_spi_s_rx.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/spi_s_rx_pkg.sv
// Shared types and defaults for the SPI slave receiver.
package spi_s_rx_pkg;

    localparam int SPI_DW      = 12;
    localparam int SPI_LEAD_IN = 1;
    localparam int SPI_SYNC    = 2;

    typedef enum logic [1:0] {WAIT_CS, IDLE, LEAD, SHIFT} spi_rx_state_t;

    // Bits needed to hold the value n (n >= 1).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_s_rx_if.sv
// SPI pin bundle plus the parallel-word result of the slave receiver.
interface spi_s_rx_if import spi_s_rx_pkg::*; #(parameter int DW = SPI_DW);

    logic          cs;
    logic          sclk;
    logic          mosi;
    logic [DW-1:0] dout;
    logic          done;
    logic          err;
    logic          busy;

    modport master (output cs, sclk, mosi, input  dout, done, err, busy);
    modport slave  (input  cs, sclk, mosi, output dout, done, err, busy);

endinterface

// File: rtl/spi_s_rx_sync.sv
// 1-bit synchronizer chain of SYNC flops plus one extra delay flop for edge detection.
module spi_s_rx_sync #(
    parameter int   SYNC    = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_d
);

    logic [SYNC-1:0] r_sh;
    logic            r_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh <= {SYNC{RST_VAL}};
            r_d  <= RST_VAL;
        end else begin
            r_sh <= {r_sh[SYNC-2:0], i_d};
            r_d  <= r_sh[SYNC-1];
        end
    end

    assign o_q = r_sh[SYNC-1];
    assign o_d = r_d;

endmodule

// File: rtl/spi_s_rx.sv
// SPI slave receiver: oversamples cs/sclk/mosi, rebuilds LSB-first frames, pulses done per word.
module spi_s_rx import spi_s_rx_pkg::*; #(
    parameter int DW      = SPI_DW,
    parameter int LEAD_IN = SPI_LEAD_IN,
    parameter int SYNC    = SPI_SYNC
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    spi_s_rx_if.slave  bus
);

    localparam int BW   = cnt_w(DW);
    localparam int LW   = cnt_w(LEAD_IN);
    localparam int HOLD = SYNC + 2;
    localparam int HW   = cnt_w(HOLD);

    logic w_cs_q, w_cs_d, w_sclk_q, w_sclk_d, w_mosi_q, w_mosi_d;
    logic w_unused;

    spi_s_rx_sync #(.SYNC(SYNC), .RST_VAL(1'b1)) u_cs (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(bus.cs),   .o_q(w_cs_q),   .o_d(w_cs_d));
    spi_s_rx_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sclk (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(bus.sclk), .o_q(w_sclk_q), .o_d(w_sclk_d));
    spi_s_rx_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_mosi (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(bus.mosi), .o_q(w_mosi_q), .o_d(w_mosi_d));

    assign w_unused = w_mosi_q;

    logic w_rise, w_cs_fall, w_tick;
    assign w_rise    = w_sclk_q & ~w_sclk_d;
    assign w_cs_fall = w_cs_d & ~w_cs_q;
    // Edge only counts while the pre-edge cs is still low.
    assign w_tick    = w_rise & ~w_cs_d;

    spi_rx_state_t r_state, w_next;
    logic [HW-1:0] r_hold;
    logic [LW-1:0] r_lead;
    logic [BW-1:0] r_bitcnt;
    logic [DW-1:0] r_sr;
    logic [DW-1:0] r_dout;
    logic          r_fin, r_done, r_err, r_busy;
    logic          w_start, w_lead_inc, w_shift, w_abort, w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= WAIT_CS;
        else          r_state <= w_next;
    end

    // Leaving WAIT_CS needs cs_d high longer than the sync reset values can fake,
    // so a frame already running when reset releases is skipped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_CS: if (w_cs_d && r_hold == HW'(HOLD)) w_next = IDLE;
            IDLE:    if (w_cs_fall) w_next = LEAD;
            LEAD: begin
                if (w_cs_d)                                     w_next = IDLE;
                else if (w_tick && r_lead == LW'(LEAD_IN - 1))  w_next = SHIFT;
            end
            SHIFT: begin
                if (w_cs_d)                                     w_next = IDLE;
                else if (w_tick && r_bitcnt == BW'(DW - 1))     w_next = WAIT_CS;
            end
            default: w_next = WAIT_CS;
        endcase
    end

    always_comb begin
        w_start    = 1'b0;
        w_lead_inc = 1'b0;
        w_shift    = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            IDLE:  w_start = w_cs_fall;
            LEAD: begin
                w_abort    = w_cs_d;
                w_lead_inc = w_tick;
            end
            SHIFT: begin
                w_abort = w_cs_d;
                w_shift = w_tick;
            end
            default: ;
        endcase
    end

    assign w_last = w_shift & (r_bitcnt == BW'(DW - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold   <= '0;
            r_lead   <= '0;
            r_bitcnt <= '0;
            r_sr     <= '0;
            r_dout   <= '0;
            r_fin    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (r_state != WAIT_CS || !w_cs_d) r_hold <= '0;
            else if (r_hold != HW'(HOLD))      r_hold <= r_hold + 1'b1;

            if (w_start)         r_lead <= '0;
            else if (w_lead_inc) r_lead <= r_lead + 1'b1;

            if (w_start)      r_sr <= '0;
            else if (w_shift) r_sr <= {w_mosi_d, r_sr[DW-1:1]};

            if (w_start || w_abort || r_fin) r_bitcnt <= '0;
            else if (w_shift)                r_bitcnt <= r_bitcnt + 1'b1;

            // Word is complete one cycle after the last shift; publish it then.
            r_fin  <= w_last;
            r_done <= r_fin;
            r_err  <= w_abort;
            if (r_fin) r_dout <= r_sr;

            if (w_start)               r_busy <= 1'b1;
            else if (w_abort || r_fin) r_busy <= 1'b0;
        end
    end

    assign bus.dout = r_dout;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_spi_s_rx.sv
// Directed + randomized bench for spi_s_rx against a bit-serial frame model.
module tb_spi_s_rx;
    import spi_s_rx_pkg::*;

    localparam int DW   = SPI_DW;
    localparam int SYNC = SPI_SYNC;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests, n_fail;
    int   n_done, n_err, n_both;
    int   done_cyc, t_rise;
    logic [DW-1:0] last_dout;

    spi_s_rx_if bus ();

    spi_s_rx dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        n_done = 0; n_err = 0; n_both = 0; done_cyc = 0; last_dout = '0;
    end
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                n_done    = n_done + 1;
                last_dout = bus.dout;
                done_cyc  = cyc;
            end
            if (bus.err)             n_err  = n_err + 1;
            if (bus.done && bus.err) n_both = n_both + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sclk period; the master puts bit b on mosi at the rising edge.
    task automatic rise(input logic b, input int h);
        bus.sclk = 1'b1;
        bus.mosi = b;
        t_rise   = cyc;
        wait_clk(h);
        bus.sclk = 1'b0;
        wait_clk(h);
    endtask

    task automatic cs_lo(input int h);
        bus.cs = 1'b0;
        wait_clk(h);
    endtask

    task automatic cs_hi();
        bus.cs = 1'b1;
        wait_clk(14);
    endtask

    // Lead-in edge carries bits[0], then one edge per data bit; extra edges carry noise.
    task automatic send(input logic [31:0] bits, input int nbits, input int h);
        cs_lo(h);
        for (int r = 0; r <= nbits; r++)
            rise((r < nbits) ? bits[r] : 1'($urandom_range(1)), h);
        cs_hi();
    endtask

    int d0, e0;
    logic [31:0] w;
    logic [DW-1:0] words2 [3];

    initial begin
        n_tests = 0; n_fail = 0; t_rise = 0;
        rst_n = 1'b0; bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        wait_clk(3);
        check("rst_dout", 32'(bus.dout), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_err",  32'(bus.err),  32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        wait_clk(14);

        // Single frame at clk/22, with latency from last pin edge to done
        d0 = n_done; e0 = n_err;
        send(32'hA5C, DW, 11);
        check("t1_ndone", 32'(n_done - d0), 32'd1);
        check("t1_dout",  32'(last_dout), 32'hA5C);
        check("t1_nerr",  32'(n_err - e0), 32'd0);
        check("t1_lat",   32'(done_cyc - t_rise), 32'(SYNC + 2));

        // Abort after 6 data edges keeps previous word
        d0 = n_done; e0 = n_err;
        w = 32'h02D;
        cs_lo(11);
        for (int r = 0; r <= 6; r++) rise(w[r], 11);
        check("t3_busy_mid", 32'(bus.busy), 32'd1);
        cs_hi();
        check("t3_nerr",  32'(n_err - e0), 32'd1);
        check("t3_ndone", 32'(n_done - d0), 32'd0);
        check("t3_dout",  32'(bus.dout), 32'hA5C);
        check("t3_busy",  32'(bus.busy), 32'd0);
        d0 = n_done;
        send(32'h3C3, DW, 11);
        check("t3b_ndone", 32'(n_done - d0), 32'd1);
        check("t3b_dout",  32'(last_dout), 32'h3C3);

        // Back-to-back frames, bit-order corners
        words2[0] = 12'h001; words2[1] = 12'h800; words2[2] = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            d0 = n_done;
            send(32'(words2[i]), DW, 11);
            check("t2_ndone", 32'(n_done - d0), 32'd1);
            check("t2_dout",  32'(last_dout), 32'(words2[i]));
        end

        // Reset in the middle of a frame
        d0 = n_done; e0 = n_err;
        w = 32'h0F5;
        cs_lo(11);
        for (int r = 0; r <= 6; r++) rise(w[r], 11);
        check("t4_busy_mid", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t4_dout0", 32'(bus.dout), 32'h0);
        check("t4_busy0", 32'(bus.busy), 32'h0);
        check("t4_done0", 32'(bus.done), 32'h0);
        check("t4_err0",  32'(bus.err),  32'h0);
        wait_clk(2);
        rst_n = 1'b1;
        for (int r = 7; r <= DW; r++) rise(w[r], 11);
        cs_hi();
        check("t4_ndone", 32'(n_done - d0), 32'd0);
        check("t4_nerr",  32'(n_err - e0), 32'd0);
        d0 = n_done;
        send(32'h123, DW, 11);
        check("t4b_ndone", 32'(n_done - d0), 32'd1);
        check("t4b_dout",  32'(last_dout), 32'h123);

        // Extra sclk edges after a full frame
        d0 = n_done; e0 = n_err;
        w = $urandom;
        send(w, DW + 4, 11);
        check("t5_ndone", 32'(n_done - d0), 32'd1);
        check("t5_dout",  32'(last_dout), 32'(w[DW-1:0]));
        check("t5_nerr",  32'(n_err - e0), 32'd0);

        // Minimum sclk half-period
        d0 = n_done;
        send(32'h5A5, DW, SYNC + 2);
        check("t6_ndone", 32'(n_done - d0), 32'd1);
        check("t6_dout",  32'(last_dout), 32'h5A5);

        // cs toggle without sclk
        d0 = n_done; e0 = n_err;
        cs_lo(10);
        cs_hi();
        check("t6b_nerr",  32'(n_err - e0), 32'd1);
        check("t6b_ndone", 32'(n_done - d0), 32'd0);

        // Random words at random legal rates
        for (int i = 0; i < 10; i++) begin
            d0 = n_done;
            w = $urandom;
            send(w, DW, $urandom_range(12, SYNC + 2));
            check("rnd_ndone", 32'(n_done - d0), 32'd1);
            check("rnd_dout",  32'(last_dout), 32'(w[DW-1:0]));
        end

        check("done_err_overlap", 32'(n_both), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
